rvfi_commit_tracker: RTL and testbench

- Retirement-side producer for the formal/trace monitor bundle.
- Sits after the MEM/WB register. Takes the per-instruction writeback packet and emits one registered commit record per retired instruction.
- Each record carries a monotonic order number, a halt flag, a trap flag and sticky integrity error codes.
- Every RVFI field driven into the monitor interface comes from this block.

---
 rtl/rvfi_pkg.sv | 50 +++++
 rtl/rvfi_trap_check.sv | 41 ++++
 rtl/rvfi_commit_tracker.sv | 134 +++++++++++++
 tb/tb_rvfi_commit_tracker.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_pkg.sv
// Shared types and constants for the RVFI commit tracker: the writeback
// packet layout, the RV32I major opcodes and the error-code bit positions.
package rvfi_pkg;

  // Writeback packet as it leaves MEM/WB. The first field is the MSB.
  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic        load_regfile;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_pkt_t;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Bit positions inside rvfi_errcode
  localparam int ERR_WATCHDOG   = 0;
  localparam int ERR_POST_HALT  = 1;
  localparam int ERR_PC_DISCONT = 2;

  // True when the opcode belongs to the base RV32I instruction set
  function automatic logic isRv32iOpcode(input logic [6:0] opc);
    return (opc == OPC_LUI)    || (opc == OPC_AUIPC)  || (opc == OPC_JAL)    ||
           (opc == OPC_JALR)   || (opc == OPC_BRANCH) || (opc == OPC_LOAD)   ||
           (opc == OPC_STORE)  || (opc == OPC_OP_IMM) || (opc == OPC_OP)     ||
           (opc == OPC_MISC_MEM) || (opc == OPC_SYSTEM);
  endfunction

endpackage

// File: rtl/rvfi_trap_check.sv
// Purely combinational trap detector for one writeback packet. Flags a
// misaligned next PC, simultaneous read and write masks, byte masks that
// are not a naturally aligned byte/half/word at the address offset, and
// opcodes outside RV32I.
module rvfi_trap_check
  import rvfi_pkg::*;
(
  input  rvfi_pkt_t wb_pkt_i,
  output logic      trap_o
);

  logic rmaskBad;
  logic wmaskBad;
  logic unusedPktBits;

  // A nonzero mask is legal only if it equals 0001, 0011 or 1111 shifted by
  // the low address bits; the 7-bit compare makes spilled patterns illegal.
  function automatic logic maskLegal(input logic [3:0] mask, input logic [1:0] offset);
    logic [6:0] wide;
    wide = {3'b000, mask};
    return (wide == (7'b0000001 << offset)) ||
           (wide == (7'b0000011 << offset)) ||
           (wide == (7'b0001111 << offset));
  endfunction

  // Evaluate every trap source and OR them together
  always_comb begin
    rmaskBad = (wb_pkt_i.mem_rmask != 4'b0000) &&
               !maskLegal(wb_pkt_i.mem_rmask, wb_pkt_i.mem_addr[1:0]);
    wmaskBad = (wb_pkt_i.mem_wmask != 4'b0000) &&
               !maskLegal(wb_pkt_i.mem_wmask, wb_pkt_i.mem_addr[1:0]);
    trap_o   = (wb_pkt_i.pc_wdata[1:0] != 2'b00) ||
               ((wb_pkt_i.mem_rmask != 4'b0000) && (wb_pkt_i.mem_wmask != 4'b0000)) ||
               rmaskBad || wmaskBad ||
               !isRv32iOpcode(wb_pkt_i.inst[6:0]);
  end

  // Most packet fields play no part in the trap decision
  assign unusedPktBits = ^wb_pkt_i;

endmodule

// File: rtl/rvfi_commit_tracker.sv
// Retirement-side producer for the RVFI monitor bundle. Turns each retiring
// writeback packet into one registered commit record with an order number,
// trap and halt flags, and sticky integrity error bits.
module rvfi_commit_tracker
  import rvfi_pkg::*;
#(
  parameter int unsigned WATCHDOG_CYCLES = 1024,
  parameter int unsigned ORDER_WIDTH     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid,
  input  logic                   wb_stall,
  input  rvfi_pkt_t              wb_pkt,
  output logic                   rvfi_commit,
  output logic [ORDER_WIDTH-1:0] rvfi_order,
  output rvfi_pkt_t              rvfi_pkt,
  output logic                   rvfi_trap,
  output logic                   rvfi_halt,
  output logic [15:0]            rvfi_errcode
);

  localparam int unsigned          WD_WIDTH = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_WIDTH-1:0]  WD_LIMIT = WD_WIDTH'(WATCHDOG_CYCLES);

  logic                   commit_q,      commit_d;
  logic [ORDER_WIDTH-1:0] orderOut_q,    orderOut_d;
  logic [ORDER_WIDTH-1:0] orderCnt_q,    orderCnt_d;
  rvfi_pkt_t              pkt_q,         pkt_d;
  logic                   trap_q,        trap_d;
  logic                   halted_q,      halted_d;
  logic [2:0]             err_q,         err_d;
  logic [WD_WIDTH-1:0]    wdCnt_q,       wdCnt_d;
  logic                   firstCommit_q, firstCommit_d;
  logic [31:0]            lastPcW_q,     lastPcW_d;

  logic      retire;
  logic      wbTrap;
  rvfi_pkt_t sanPkt;

  rvfi_trap_check u_trap_check (
    .wb_pkt_i (wb_pkt),
    .trap_o   (wbTrap)
  );

  assign retire = wb_valid & ~wb_stall & ~halted_q;

  // Drop the destination write when the instruction does not really write rd
  always_comb begin
    sanPkt = wb_pkt;
    if (!wb_pkt.load_regfile || (wb_pkt.rd_addr == 5'd0)) begin
      sanPkt.rd_addr  = 5'd0;
      sanPkt.rd_wdata = 32'd0;
    end
  end

  // Next-state for the commit record, order counter, halt, watchdog and errors
  always_comb begin
    commit_d      = retire;
    orderOut_d    = orderOut_q;
    orderCnt_d    = orderCnt_q;
    pkt_d         = pkt_q;
    trap_d        = trap_q;
    halted_d      = halted_q;
    err_d         = err_q;
    wdCnt_d       = wdCnt_q;
    firstCommit_d = firstCommit_q;
    lastPcW_d     = lastPcW_q;

    if (retire) begin
      orderOut_d    = orderCnt_q;
      orderCnt_d    = orderCnt_q + ORDER_WIDTH'(1);
      pkt_d         = sanPkt;
      trap_d        = wbTrap;
      lastPcW_d     = wb_pkt.pc_wdata;
      firstCommit_d = 1'b0;
      if (wb_pkt.pc_wdata == wb_pkt.pc_rdata) begin
        halted_d = 1'b1;
      end
      if (!firstCommit_q && (wb_pkt.pc_rdata != lastPcW_q)) begin
        err_d[ERR_PC_DISCONT] = 1'b1;
      end
    end

    if (retire) begin
      wdCnt_d = '0;
    end else if (!halted_q && (wdCnt_q != WD_LIMIT)) begin
      wdCnt_d = wdCnt_q + WD_WIDTH'(1);
    end

    if (wdCnt_q == WD_LIMIT) begin
      err_d[ERR_WATCHDOG] = 1'b1;
    end

    if (wb_valid && !wb_stall && halted_q) begin
      err_d[ERR_POST_HALT] = 1'b1;
    end
  end

  // State registers; reset wins over any retire or stall in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_q      <= 1'b0;
      orderOut_q    <= '0;
      orderCnt_q    <= '0;
      pkt_q         <= '0;
      trap_q        <= 1'b0;
      halted_q      <= 1'b0;
      err_q         <= '0;
      wdCnt_q       <= '0;
      firstCommit_q <= 1'b1;
      lastPcW_q     <= '0;
    end else begin
      commit_q      <= commit_d;
      orderOut_q    <= orderOut_d;
      orderCnt_q    <= orderCnt_d;
      pkt_q         <= pkt_d;
      trap_q        <= trap_d;
      halted_q      <= halted_d;
      err_q         <= err_d;
      wdCnt_q       <= wdCnt_d;
      firstCommit_q <= firstCommit_d;
      lastPcW_q     <= lastPcW_d;
    end
  end

  assign rvfi_commit  = commit_q;
  assign rvfi_order   = orderOut_q;
  assign rvfi_pkt     = pkt_q;
  assign rvfi_trap    = trap_q;
  assign rvfi_halt    = halted_q;
  assign rvfi_errcode = {13'd0, err_q};

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Self-checking bench for rvfi_commit_tracker. Expected commit records are
// queued as retiring packets are driven and popped when rvfi_commit fires.
module tb_rvfi_commit_tracker;
  import rvfi_pkg::*;

  localparam int unsigned WD = 16;

  typedef struct packed {
    logic [63:0] order;
    logic        trap;
    logic        halt;
    logic [15:0] err;
    logic [31:0] pcr;
    logic [4:0]  rda;
    logic [31:0] rdw;
  } rec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic        lrf;
    logic [4:0]  rda;
    logic [31:0] rdw;
    logic [31:0] pcwAdd;
    logic        expTrap;
    logic [4:0]  expRda;
    logic [31:0] expRdw;
  } tcase_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_stall;
  rvfi_pkt_t   wb_pkt;
  logic        rvfi_commit;
  logic [63:0] rvfi_order;
  rvfi_pkt_t   rvfi_pkt;
  logic        rvfi_trap;
  logic        rvfi_halt;
  logic [15:0] rvfi_errcode;

  int   total = 0;
  int   bad   = 0;
  rec_t sbQ[$];

  rvfi_commit_tracker #(
    .WATCHDOG_CYCLES (WD),
    .ORDER_WIDTH     (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_stall     (wb_stall),
    .wb_pkt       (wb_pkt),
    .rvfi_commit  (rvfi_commit),
    .rvfi_order   (rvfi_order),
    .rvfi_pkt     (rvfi_pkt),
    .rvfi_trap    (rvfi_trap),
    .rvfi_halt    (rvfi_halt),
    .rvfi_errcode (rvfi_errcode)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

  // Ordinary ALU-style packet with a real rd write and no memory access
  function automatic rvfi_pkt_t mkPkt(input logic [31:0] inst, input logic [31:0] pcr,
                                      input logic [31:0] pcw);
    rvfi_pkt_t p;
    p              = '0;
    p.inst         = inst;
    p.rs1_addr     = 5'd2;
    p.rs2_addr     = 5'd3;
    p.rs1_rdata    = 32'h1111_0000;
    p.rs2_rdata    = 32'h2222_0000;
    p.load_regfile = 1'b1;
    p.rd_addr      = 5'd1;
    p.rd_wdata     = pcr ^ 32'h5a5a_0000;
    p.pc_rdata     = pcr;
    p.pc_wdata     = pcw;
    return p;
  endfunction

  function automatic rec_t mkExp(input int order, input logic trap, input logic halt,
                                 input logic [15:0] err, input logic [31:0] pcr,
                                 input logic [4:0] rda, input logic [31:0] rdw);
    rec_t r;
    r.order = 64'(order);
    r.trap  = trap;
    r.halt  = halt;
    r.err   = err;
    r.pcr   = pcr;
    r.rda   = rda;
    r.rdw   = rdw;
    return r;
  endfunction

  function automatic rec_t obsRec();
    rec_t r;
    r.order = rvfi_order;
    r.trap  = rvfi_trap;
    r.halt  = rvfi_halt;
    r.err   = rvfi_errcode;
    r.pcr   = rvfi_pkt.pc_rdata;
    r.rda   = rvfi_pkt.rd_addr;
    r.rdw   = rvfi_pkt.rd_wdata;
    return r;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    wb_valid = 1'b0;
    wb_stall = 1'b0;
    wb_pkt   = '0;
    sbQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset held while a retirable packet is present: nothing may commit
  task automatic test_reset();
    rst      = 1'b1;
    wb_valid = 1'b1;
    wb_stall = 1'b0;
    wb_pkt   = mkPkt(32'h0010_0093, 32'h4000_0000, 32'h4000_0004);
    repeat (3) @(negedge clk);
    total++;
    if (rvfi_commit !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_commit: got %b, required 0", rvfi_commit);
    end
    total++;
    if ({rvfi_order, rvfi_trap, rvfi_halt, rvfi_errcode, rvfi_pkt} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: order=%h trap=%b halt=%b err=%h pkt=%h, required all 0",
               rvfi_order, rvfi_trap, rvfi_halt, rvfi_errcode, rvfi_pkt);
    end
    wb_valid = 1'b0;
  endtask

  // Three retirements in consecutive cycles give three consecutive pulses
  task automatic test_back_to_back();
    rec_t e, o;
    doReset();
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1;
      wb_pkt   = mkPkt(32'h0010_0093, 32'h4000_0000 + 32'(4 * i), 32'h4000_0004 + 32'(4 * i));
      sbQ.push_back(mkExp(i, 1'b0, 1'b0, 16'h0000, wb_pkt.pc_rdata, 5'd1, wb_pkt.rd_wdata));
      @(negedge clk);
      total++;
      if (rvfi_commit !== 1'b1 || sbQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL b2b_commit%0d: commit=%b queued=%0d, required commit=1", i, rvfi_commit, sbQ.size());
      end else begin
        e = sbQ.pop_front();
        o = obsRec();
        if (o !== e) begin
          bad++;
          $display("[TB] FAIL b2b_rec%0d: got %h, required %h", i, o, e);
        end
      end
    end
    wb_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rvfi_commit !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_idle: commit=%b, required 0", rvfi_commit);
    end
  endtask

  // A stalled instruction retires exactly once after the stall drops
  task automatic test_stall();
    rec_t e, o;
    doReset();
    wb_valid = 1'b1;
    wb_pkt   = mkPkt(32'h0010_0093, 32'h4000_0000, 32'h4000_0004);
    sbQ.push_back(mkExp(0, 1'b0, 1'b0, 16'h0000, 32'h4000_0000, 5'd1, wb_pkt.rd_wdata));
    @(negedge clk);
    total++;
    if (rvfi_commit !== 1'b1 || sbQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL stall_first: commit=%b, required 1", rvfi_commit);
    end else begin
      e = sbQ.pop_front();
      o = obsRec();
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL stall_first_rec: got %h, required %h", o, e);
      end
    end
    wb_stall = 1'b1;
    wb_pkt   = mkPkt(32'h0000_0033, 32'h4000_0004, 32'h4000_0008);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (rvfi_commit !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_cycle%0d: commit=%b, required 0", c, rvfi_commit);
      end
    end
    wb_stall = 1'b0;
    sbQ.push_back(mkExp(1, 1'b0, 1'b0, 16'h0000, 32'h4000_0004, 5'd1, wb_pkt.rd_wdata));
    @(negedge clk);
    wb_valid = 1'b0;
    total++;
    if (rvfi_commit !== 1'b1 || sbQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL stall_release: commit=%b, required 1", rvfi_commit);
    end else begin
      e = sbQ.pop_front();
      o = obsRec();
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL stall_release_rec: got %h, required %h", o, e);
      end
    end
    @(negedge clk);
    total++;
    if (rvfi_commit !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_extra: commit=%b, required 0", rvfi_commit);
    end
  endtask

  // Self-loop JAL halts; later retire attempts are refused and flagged
  task automatic test_halt();
    rec_t e, o;
    doReset();
    wb_valid = 1'b1;
    wb_pkt   = mkPkt(32'h0000_006F, 32'h4000_0010, 32'h4000_0010);
    sbQ.push_back(mkExp(0, 1'b0, 1'b1, 16'h0000, 32'h4000_0010, 5'd1, wb_pkt.rd_wdata));
    @(negedge clk);
    total++;
    if (rvfi_commit !== 1'b1 || sbQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL halt_commit: commit=%b, required 1", rvfi_commit);
    end else begin
      e = sbQ.pop_front();
      o = obsRec();
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL halt_rec: got %h, required %h", o, e);
      end
    end
    wb_pkt = mkPkt(32'h0010_0093, 32'h4000_0010, 32'h4000_0014);
    @(negedge clk);
    wb_valid = 1'b0;
    total++;
    if ({rvfi_commit, rvfi_halt, rvfi_errcode} !== {1'b0, 1'b1, 16'h0002}) begin
      bad++;
      $display("[TB] FAIL post_halt: commit=%b halt=%b err=%h, required commit=0 halt=1 err=0002",
               rvfi_commit, rvfi_halt, rvfi_errcode);
    end
    repeat (WD + 4) @(negedge clk);
    total++;
    if ({rvfi_commit, rvfi_halt, rvfi_errcode} !== {1'b0, 1'b1, 16'h0002}) begin
      bad++;
      $display("[TB] FAIL halt_sticky: commit=%b halt=%b err=%h, required commit=0 halt=1 err=0002",
               rvfi_commit, rvfi_halt, rvfi_errcode);
    end
  endtask

  // Trap sources and rd sanitising over a contiguous run of retirements
  task automatic test_trap_sanitise();
    tcase_t tc[8];
    rec_t e, o;
    logic [31:0] pcr;
    tc[0] = '{32'h0000_2003, 32'h4000_1002, 4'hF, 4'h0, 1'b1, 5'd0, 32'h1234, 32'd4, 1'b1, 5'd0, 32'h0};
    tc[1] = '{32'h0000_2003, 32'h4000_1002, 4'hC, 4'h0, 1'b1, 5'd5, 32'hCAFE, 32'd4, 1'b0, 5'd5, 32'hCAFE};
    tc[2] = '{32'h0000_2003, 32'h4000_1000, 4'h1, 4'h0, 1'b0, 5'd3, 32'h0077, 32'd4, 1'b0, 5'd0, 32'h0};
    tc[3] = '{32'h0011_2023, 32'h4000_1001, 4'h0, 4'h2, 1'b0, 5'd0, 32'h0000, 32'd4, 1'b0, 5'd0, 32'h0};
    tc[4] = '{32'h0011_2023, 32'h4000_1003, 4'h0, 4'h3, 1'b0, 5'd0, 32'h0000, 32'd4, 1'b1, 5'd0, 32'h0};
    tc[5] = '{32'h0000_2003, 32'h4000_1000, 4'h1, 4'h1, 1'b1, 5'd7, 32'h0042, 32'd4, 1'b1, 5'd7, 32'h0042};
    tc[6] = '{32'h0000_0000, 32'h0000_0000, 4'h0, 4'h0, 1'b1, 5'd8, 32'h0099, 32'd4, 1'b1, 5'd8, 32'h0099};
    tc[7] = '{32'h0010_0093, 32'h0000_0000, 4'h0, 4'h0, 1'b1, 5'd1, 32'h0055, 32'd2, 1'b1, 5'd1, 32'h0055};
    doReset();
    for (int i = 0; i < 8; i++) begin
      pcr                 = 32'h4000_0000 + 32'(4 * i);
      wb_pkt              = mkPkt(tc[i].inst, pcr, pcr + tc[i].pcwAdd);
      wb_pkt.mem_addr     = tc[i].addr;
      wb_pkt.mem_rmask    = tc[i].rm;
      wb_pkt.mem_wmask    = tc[i].wm;
      wb_pkt.load_regfile = tc[i].lrf;
      wb_pkt.rd_addr      = tc[i].rda;
      wb_pkt.rd_wdata     = tc[i].rdw;
      wb_valid            = 1'b1;
      sbQ.push_back(mkExp(i, tc[i].expTrap, 1'b0, 16'h0000, pcr, tc[i].expRda, tc[i].expRdw));
      @(negedge clk);
      total++;
      if (rvfi_commit !== 1'b1 || sbQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL trap_commit%0d: commit=%b, required 1", i, rvfi_commit);
      end else begin
        e = sbQ.pop_front();
        o = obsRec();
        if (o !== e) begin
          bad++;
          $display("[TB] FAIL trap_rec%0d: got %h, required %h", i, o, e);
        end
      end
    end
    wb_valid = 1'b0;
  endtask

  // A jump in PC between commits sets the sticky discontinuity bit
  task automatic test_pc_discont();
    rec_t e, o;
    logic [31:0] pcrTab [3];
    logic [15:0] errTab [3];
    pcrTab = '{32'h4000_0004, 32'h4000_0010, 32'h4000_0014};
    errTab = '{16'h0000, 16'h0004, 16'h0004};
    doReset();
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1;
      wb_pkt   = mkPkt(32'h0010_0093, pcrTab[i], pcrTab[i] + 32'd4);
      sbQ.push_back(mkExp(i, 1'b0, 1'b0, errTab[i], pcrTab[i], 5'd1, wb_pkt.rd_wdata));
      @(negedge clk);
      total++;
      if (rvfi_commit !== 1'b1 || sbQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL disc_commit%0d: commit=%b, required 1", i, rvfi_commit);
      end else begin
        e = sbQ.pop_front();
        o = obsRec();
        if (o !== e) begin
          bad++;
          $display("[TB] FAIL disc_rec%0d: got %h, required %h", i, o, e);
        end
      end
    end
    wb_valid = 1'b0;
  endtask

  // Idle watchdog, then a reset asserted in the middle of a stall
  task automatic test_watchdog_reset();
    rec_t e, o;
    doReset();
    for (int k = 1; k <= WD + 4; k++) begin
      @(negedge clk);
      total++;
      if (rvfi_errcode !== ((k >= WD + 1) ? 16'h0001 : 16'h0000)) begin
        bad++;
        $display("[TB] FAIL watchdog_cycle%0d: err=%h, required %h", k, rvfi_errcode,
                 (k >= WD + 1) ? 16'h0001 : 16'h0000);
      end
    end
    wb_valid = 1'b1;
    wb_pkt   = mkPkt(32'h0010_0093, 32'h4000_0000, 32'h4000_0004);
    sbQ.push_back(mkExp(0, 1'b0, 1'b0, 16'h0001, 32'h4000_0000, 5'd1, wb_pkt.rd_wdata));
    @(negedge clk);
    total++;
    if (rvfi_commit !== 1'b1 || sbQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL wd_commit: commit=%b, required 1", rvfi_commit);
    end else begin
      e = sbQ.pop_front();
      o = obsRec();
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL wd_rec: got %h, required %h", o, e);
      end
    end
    wb_stall = 1'b1;
    wb_pkt   = mkPkt(32'h0000_0033, 32'h4000_0004, 32'h4000_0008);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({rvfi_commit, rvfi_order, rvfi_trap, rvfi_halt, rvfi_errcode, rvfi_pkt} !== '0) begin
      bad++;
      $display("[TB] FAIL midstall_reset: commit=%b order=%h trap=%b halt=%b err=%h pkt=%h, required all 0",
               rvfi_commit, rvfi_order, rvfi_trap, rvfi_halt, rvfi_errcode, rvfi_pkt);
    end
    rst      = 1'b0;
    wb_stall = 1'b0;
    sbQ.push_back(mkExp(0, 1'b0, 1'b0, 16'h0000, 32'h4000_0004, 5'd1, wb_pkt.rd_wdata));
    @(negedge clk);
    wb_valid = 1'b0;
    total++;
    if (rvfi_commit !== 1'b1 || sbQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL after_reset_commit: commit=%b, required 1", rvfi_commit);
    end else begin
      e = sbQ.pop_front();
      o = obsRec();
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL after_reset_rec: got %h, required %h", o, e);
      end
    end
  endtask

  // Run every scenario in order and report
  initial begin
    rst      = 1'b1;
    wb_valid = 1'b0;
    wb_stall = 1'b0;
    wb_pkt   = '0;
    $display("[TB] starting rvfi_commit_tracker checks");
    test_reset();
    test_back_to_back();
    test_stall();
    test_halt();
    test_trap_sanitise();
    test_pc_discont();
    test_watchdog_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
